// File: rtl/rstation_issue.sv
// rstation_issue: in-order reservation-station queue and issue stage feeding the register file,
// followed by a one-cycle execute stage. Optional same-cycle empty-queue bypass: RS_BYPASS_EN.
module rstation_issue #(
    parameter int DEPTH = 4,
    parameter int OP_W  = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             in_a_addr,
    input  logic [2:0]             in_b_addr,
    input  logic [2:0]             in_dest_addr,
    input  logic                   in_dest_wr,
    input  logic                   in_w_flags,
    input  logic [OP_W-1:0]        in_op,
    input  logic [15:0]            in_pc,
    input  logic                   ex_stall,
    input  logic                   flush,
    output logic [2:0]             r_a_addr,
    output logic [2:0]             r_b_addr,
    output logic [15:0]            r_pc,
    output logic                   ex_valid,
    output logic [OP_W-1:0]        ex_op,
    output logic                   dest_r_wr,
    output logic [2:0]             dest_r_addr,
    output logic                   dest_w_flags,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [2:0]       q_a    [DEPTH];
    logic [2:0]       q_b    [DEPTH];
    logic [2:0]       q_dest [DEPTH];
    logic             q_wr   [DEPTH];
    logic             q_wf   [DEPTH];
    logic [OP_W-1:0]  q_op   [DEPTH];
    logic [15:0]      q_pc   [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    logic empty;
    logic full;
    logic push;
    logic push_q;
    logic pop;
    logic bypass;
    logic issue;

    logic [2:0]      iss_a;
    logic [2:0]      iss_b;
    logic [2:0]      iss_dest;
    logic            iss_wr;
    logic            iss_wf;
    logic [OP_W-1:0] iss_op;
    logic [15:0]     iss_pc;

    // Execute-stage copies of the read fields, replayed to the register file while stalled.
    logic [2:0]  ex_a;
    logic [2:0]  ex_b;
    logic [15:0] ex_pc;
    logic        ex_wr;
    logic        ex_wf;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign in_ready = ~full & ~rst & ~flush;
    assign push     = in_valid & in_ready;

`ifdef RS_BYPASS_EN
    assign bypass = empty & push & ~ex_stall;
`else
    assign bypass = 1'b0;
`endif

    assign pop    = ~empty & ~ex_stall & ~flush;
    assign issue  = pop | bypass;
    assign push_q = push & ~bypass;

    always_comb begin
        iss_a    = q_a[head];
        iss_b    = q_b[head];
        iss_dest = q_dest[head];
        iss_wr   = q_wr[head];
        iss_wf   = q_wf[head];
        iss_op   = q_op[head];
        iss_pc   = q_pc[head];
        if (bypass) begin
            iss_a    = in_a_addr;
            iss_b    = in_b_addr;
            iss_dest = in_dest_addr;
            iss_wr   = in_dest_wr;
            iss_wf   = in_w_flags;
            iss_op   = in_op;
            iss_pc   = in_pc;
        end
    end

    always_comb begin
        r_a_addr = '0;
        r_b_addr = '0;
        r_pc     = '0;
        if (!rst && !flush) begin
            if (issue) begin
                r_a_addr = iss_a;
                r_b_addr = iss_b;
                r_pc     = iss_pc;
            end else if (ex_stall) begin
                r_a_addr = ex_a;
                r_b_addr = ex_b;
                r_pc     = ex_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_q) begin
            q_a[tail]    <= in_a_addr;
            q_b[tail]    <= in_b_addr;
            q_dest[tail] <= in_dest_addr;
            q_wr[tail]   <= in_dest_wr;
            q_wf[tail]   <= in_w_flags;
            q_op[tail]   <= in_op;
            q_pc[tail]   <= in_pc;
        end
    end

    // Occupancy is tracked explicitly; full/empty never come from pointer compare.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_q) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push_q, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Idle cycles clear the execute registers so a later stall replays zeros, not stale fields.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ex_valid    <= 1'b0;
            ex_op       <= '0;
            dest_r_addr <= '0;
            ex_wr       <= 1'b0;
            ex_wf       <= 1'b0;
            ex_a        <= '0;
            ex_b        <= '0;
            ex_pc       <= '0;
        end else if (!ex_stall) begin
            ex_valid <= issue;
            if (issue) begin
                ex_op       <= iss_op;
                dest_r_addr <= iss_dest;
                ex_wr       <= iss_wr;
                ex_wf       <= iss_wf;
                ex_a        <= iss_a;
                ex_b        <= iss_b;
                ex_pc       <= iss_pc;
            end else begin
                ex_op       <= '0;
                dest_r_addr <= '0;
                ex_wr       <= 1'b0;
                ex_wf       <= 1'b0;
                ex_a        <= '0;
                ex_b        <= '0;
                ex_pc       <= '0;
            end
        end
    end

    assign dest_r_wr    = ex_valid & ex_wr & ~ex_stall;
    assign dest_w_flags = ex_valid & ex_wf & ~ex_stall;

endmodule

// File: tb/tb_rstation_issue.sv
// Bench for rstation_issue: queue-level reference model checked every cycle, plus directed
// scenarios with literal expectations. Follows RS_BYPASS_EN when defined.
module tb_rstation_issue;
    localparam int DEPTH = 4;
    localparam int OP_W  = 5;

    typedef struct packed {
        logic [2:0]  a;
        logic [2:0]  b;
        logic [2:0]  d;
        logic        wr;
        logic        wf;
        logic [4:0]  op;
        logic [15:0] pc;
    } op_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_a_addr;
    logic [2:0]  in_b_addr;
    logic [2:0]  in_dest_addr;
    logic        in_dest_wr;
    logic        in_w_flags;
    logic [4:0]  in_op;
    logic [15:0] in_pc;
    logic        ex_stall;
    logic        flush;
    logic [2:0]  r_a_addr;
    logic [2:0]  r_b_addr;
    logic [15:0] r_pc;
    logic        ex_valid;
    logic [4:0]  ex_op;
    logic        dest_r_wr;
    logic [2:0]  dest_r_addr;
    logic        dest_w_flags;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;

    rstation_issue #(.DEPTH(DEPTH), .OP_W(OP_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a_addr(in_a_addr), .in_b_addr(in_b_addr), .in_dest_addr(in_dest_addr),
        .in_dest_wr(in_dest_wr), .in_w_flags(in_w_flags), .in_op(in_op), .in_pc(in_pc),
        .ex_stall(ex_stall), .flush(flush),
        .r_a_addr(r_a_addr), .r_b_addr(r_b_addr), .r_pc(r_pc),
        .ex_valid(ex_valid), .ex_op(ex_op),
        .dest_r_wr(dest_r_wr), .dest_r_addr(dest_r_addr), .dest_w_flags(dest_w_flags),
        .count(count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of ops plus one execute slot, advanced once per cycle.
    op_t mq[$];
    op_t m_ex;
    logic m_exv;

    initial begin
        op_t cur, rd;
        int n;
        logic e_ready, byp;
        m_ex  = '0;
        m_exv = 1'b0;
        forever begin
            @(negedge clk);
            n   = mq.size();
            cur = '{a: in_a_addr, b: in_b_addr, d: in_dest_addr, wr: in_dest_wr,
                    wf: in_w_flags, op: in_op, pc: in_pc};
            e_ready = (n < DEPTH) && !rst && !flush;
            byp = 1'b0;
`ifdef RS_BYPASS_EN
            byp = (n == 0) && in_valid && e_ready && !ex_stall;
`endif
            rd = '0;
            if (rst || flush)              rd = '0;
            else if (!ex_stall && n > 0)   rd = mq[0];
            else if (byp)                  rd = cur;
            else if (ex_stall)             rd = m_ex;

            chk("m_in_ready", 32'(in_ready), 32'(e_ready));
            chk("m_count", 32'(count), 32'(n));
            chk("m_r_a_addr", 32'(r_a_addr), 32'(rd.a));
            chk("m_r_b_addr", 32'(r_b_addr), 32'(rd.b));
            chk("m_r_pc", 32'(r_pc), 32'(rd.pc));
            chk("m_ex_valid", 32'(ex_valid), 32'(m_exv));
            chk("m_ex_op", 32'(ex_op), 32'(m_exv ? m_ex.op : 5'd0));
            chk("m_dest_r_addr", 32'(dest_r_addr), 32'(m_exv ? m_ex.d : 3'd0));
            chk("m_dest_r_wr", 32'(dest_r_wr), 32'(m_exv && m_ex.wr && !ex_stall));
            chk("m_dest_w_flags", 32'(dest_w_flags), 32'(m_exv && m_ex.wf && !ex_stall));

            if (rst || flush) begin
                mq.delete();
                m_ex  = '0;
                m_exv = 1'b0;
            end else begin
                if (!ex_stall) begin
                    if (n > 0) begin
                        m_ex  = mq.pop_front();
                        m_exv = 1'b1;
                    end else if (byp) begin
                        m_ex  = cur;
                        m_exv = 1'b1;
                    end else begin
                        m_ex  = '0;
                        m_exv = 1'b0;
                    end
                end
                if (in_valid && e_ready && !byp) mq.push_back(cur);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [2:0] a, input logic [2:0] b, input logic [2:0] d,
                       input logic wr, input logic wf, input logic [4:0] op, input logic [15:0] pc);
        in_valid     = 1'b1;
        in_a_addr    = a;
        in_b_addr    = b;
        in_dest_addr = d;
        in_dest_wr   = wr;
        in_w_flags   = wf;
        in_op        = op;
        in_pc        = pc;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; ex_stall = 1'b0;
        in_valid = 1'b0; in_a_addr = '0; in_b_addr = '0; in_dest_addr = '0;
        in_dest_wr = 1'b0; in_w_flags = 1'b0; in_op = '0; in_pc = '0;

        // reset state
        repeat (2) tick();
        #2;
        chk("rst_count", 32'(count), 0);
        chk("rst_ex_valid", 32'(ex_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_r_a", 32'(r_a_addr), 0);
        chk("rst_r_pc", 32'(r_pc), 0);
        chk("rst_dest_wr", 32'(dest_r_wr), 0);
        chk("rst_ex_op", 32'(ex_op), 0);

        // single op through the pipe
        tick();
        rst = 1'b0;
        put(3'd1, 3'd2, 3'd4, 1'b1, 1'b0, 5'd3, 16'h0010);
        #2 chk("t1_in_ready", 32'(in_ready), 1);
`ifdef RS_BYPASS_EN
        chk("t1_byp_r_a", 32'(r_a_addr), 1);
        tick(); idle();
        #2 chk("t1_dest_wr", 32'(dest_r_wr), 1);
        chk("t1_dest_addr", 32'(dest_r_addr), 4);
        chk("t1_count", 32'(count), 0);
`else
        chk("t1_r_a_early", 32'(r_a_addr), 0);
        tick(); idle();
        #2 chk("t1_r_a", 32'(r_a_addr), 1);
        chk("t1_r_b", 32'(r_b_addr), 2);
        chk("t1_count1", 32'(count), 1);
        tick();
        #2 chk("t1_dest_wr", 32'(dest_r_wr), 1);
        chk("t1_dest_addr", 32'(dest_r_addr), 4);
        chk("t1_ex_op", 32'(ex_op), 3);
        chk("t1_count", 32'(count), 0);
`endif
        tick();

        // fill while stalled, refuse a fifth, then drain in order
        ex_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            put(3'(i + 1), 3'(i + 2), 3'(i + 4), 1'b1, 1'b0, 5'(8 + i), 16'h0100 + 16'(i));
            tick();
        end
        put(3'd7, 3'd7, 3'd7, 1'b1, 1'b1, 5'd31, 16'hFFFF);
        #2 chk("t2_count_full", 32'(count), 4);
        chk("t2_in_ready", 32'(in_ready), 0);
        tick();
        idle();
        ex_stall = 1'b0;
        #2 chk("t2_count_no5th", 32'(count), 4);
        chk("t2_r_a0", 32'(r_a_addr), 1);
        for (int i = 1; i < 4; i++) begin
            tick();
            #2 chk("t2_r_a", 32'(r_a_addr), 32'(i + 1));
            chk("t2_dest", 32'(dest_r_addr), 32'(i + 3));
            chk("t2_dest_wr", 32'(dest_r_wr), 1);
        end
        tick();
        #2 chk("t2_last_dest", 32'(dest_r_addr), 7);
        chk("t2_empty", 32'(count), 0);
        chk("t2_r_a_idle", 32'(r_a_addr), 0);
        tick();

        // stall with a live execute op: replay reads, single delayed write
        put(3'd5, 3'd6, 3'd2, 1'b1, 1'b1, 5'd4, 16'h0200);
        tick(); idle();
`ifndef RS_BYPASS_EN
        tick();
`endif
        ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2 chk("t3_r_a_hold", 32'(r_a_addr), 5);
            chk("t3_r_b_hold", 32'(r_b_addr), 6);
            chk("t3_r_pc_hold", 32'(r_pc), 32'h0200);
            chk("t3_wr_stalled", 32'(dest_r_wr), 0);
            tick();
        end
        ex_stall = 1'b0;
        #2 chk("t3_wr_once", 32'(dest_r_wr), 1);
        chk("t3_flags_once", 32'(dest_w_flags), 1);
        chk("t3_dest", 32'(dest_r_addr), 2);
        tick();
        #2 chk("t3_wr_after", 32'(dest_r_wr), 0);

        // flush with three queued ops and a stalled execute op
        tick();
        put(3'd1, 3'd1, 3'd6, 1'b1, 1'b0, 5'd2, 16'h0300);
        tick(); idle();
`ifndef RS_BYPASS_EN
        tick();
`endif
        ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            put(3'(i + 2), 3'(i + 3), 3'(i + 1), 1'b1, 1'b0, 5'(20 + i), 16'h0310 + 16'(i));
            tick();
        end
        flush = 1'b1;
        put(3'd7, 3'd7, 3'd7, 1'b1, 1'b1, 5'd9, 16'h0399);
        #2 chk("t4_in_ready", 32'(in_ready), 0);
        chk("t4_count_pre", 32'(count), 3);
        chk("t4_ex_valid_pre", 32'(ex_valid), 1);
        tick();
        flush = 1'b0; ex_stall = 1'b0; idle();
        #2 chk("t4_count", 32'(count), 0);
        chk("t4_ex_valid", 32'(ex_valid), 0);
        chk("t4_dest_wr", 32'(dest_r_wr), 0);
        tick();
        put(3'd7, 3'd0, 3'd3, 1'b1, 1'b0, 5'd1, 16'h0400);
        tick(); idle();
`ifndef RS_BYPASS_EN
        #2 chk("t4_post_r_a", 32'(r_a_addr), 7);
        tick();
`endif
        #2 chk("t4_post_wr", 32'(dest_r_wr), 1);
        chk("t4_post_dest", 32'(dest_r_addr), 3);
        tick();

        // full and issuing refuses a push, then push and pop together
        ex_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            put(3'(i), 3'(i), 3'(i), 1'b0, 1'b1, 5'(i), 16'h0500 + 16'(i));
            tick();
        end
        ex_stall = 1'b0;
        put(3'd6, 3'd5, 3'd4, 1'b1, 1'b1, 5'd17, 16'h0555);
        #2 chk("t5_in_ready_full", 32'(in_ready), 0);
        chk("t5_count_full", 32'(count), 4);
        tick();
        #2 chk("t5_count_3", 32'(count), 3);
        chk("t5_in_ready", 32'(in_ready), 1);
        tick();
        #2 chk("t5_count_steady", 32'(count), 3);
        idle();
        repeat (6) tick();

        // same-cycle bypass versus queued latency
        put(3'd3, 3'd1, 3'd0, 1'b0, 1'b0, 5'd0, 16'h1234);
`ifdef RS_BYPASS_EN
        #2 chk("t6_r_a", 32'(r_a_addr), 3);
        chk("t6_r_pc", 32'(r_pc), 32'h1234);
        chk("t6_count", 32'(count), 0);
        tick(); idle();
        #2 chk("t6_count_after", 32'(count), 0);
        chk("t6_ex_valid", 32'(ex_valid), 1);
`else
        #2 chk("t6_r_a_early", 32'(r_a_addr), 0);
        chk("t6_r_pc_early", 32'(r_pc), 0);
        tick(); idle();
        #2 chk("t6_r_a", 32'(r_a_addr), 3);
        chk("t6_r_pc", 32'(r_pc), 32'h1234);
        chk("t6_count", 32'(count), 1);
`endif
        repeat (2) tick();

        // reset mid-stall drops the pending write
        put(3'd2, 3'd3, 3'd5, 1'b1, 1'b0, 5'd6, 16'h0600);
        tick(); idle();
`ifndef RS_BYPASS_EN
        tick();
`endif
        ex_stall = 1'b1;
        tick();
        rst = 1'b1;
        #2 chk("t7_wr_in_rst", 32'(dest_r_wr), 0);
        tick();
        rst = 1'b0; ex_stall = 1'b0;
        #2 chk("t7_ex_valid", 32'(ex_valid), 0);
        chk("t7_wr", 32'(dest_r_wr), 0);
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
